slot_alloc: RTL and testbench
=============================

SLOT_ALLOC -- requirements
Module: slot_alloc

Interface
REQ-001 Parameter NUM_ENTRIES, default 12, number of allocatable slots (2..64).
REQ-002 Parameter ALLOC_PORTS, default 2, allocation requests per cycle (1..4).
REQ-003 Parameter FREE_PORTS, default 2, free requests per cycle (1..4).
REQ-004 Derived IDX_W = $clog2(NUM_ENTRIES); CNT_W = $clog2(NUM_ENTRIES+1).
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  return every slot to free state.
REQ-008 alloc_req  input  ALLOC_PORTS  per-port allocation request.
REQ-009 alloc_gnt  output  ALLOC_PORTS  per-port grant, combinational from state and alloc_req.
REQ-010 alloc_idx  output  ALLOC_PORTS x IDX_W  granted slot index per port, valid only when alloc_gnt set.
REQ-011 free_valid  input  FREE_PORTS  per-port free request.
REQ-012 free_idx  input  FREE_PORTS x IDX_W  slot index to free.
REQ-013 free_count  output  CNT_W  registered number of free slots.
REQ-014 empty  output  1  registered, high when free_count equals NUM_ENTRIES (no slot in use).
REQ-015 full  output  1  registered, high when free_count equals 0.

Function
REQ-016 State SHALL be a NUM_ENTRIES-bit busy bitmap; bit set means slot in use.
REQ-017 Grant selection SHALL be lowest-index-first: lowest requesting port receives lowest free slot, next requesting port receives next-lowest free slot, and so on.
REQ-018 Non-requesting ports SHALL NOT consume a slot; alloc_gnt for them SHALL be 0 and alloc_idx SHALL be 0.
REQ-019 When fewer free slots than requesting ports exist, the lowest-numbered requesting ports SHALL be granted and the rest SHALL see alloc_gnt=0, alloc_idx=0.
REQ-020 Granted slots SHALL become busy on the next rising edge; grant-to-busy latency is exactly one cycle.
REQ-021 Freed slots SHALL become free on the next rising edge and SHALL NOT be grantable in the cycle they are freed.
REQ-022 Free of an already-free slot SHALL be ignored with no effect on bitmap or free_count.
REQ-023 Two free ports naming the same slot in one cycle SHALL free it once; free_count SHALL drop by one only.
REQ-024 free_idx >= NUM_ENTRIES SHALL be ignored.
REQ-025 free_count next value SHALL equal popcount of next bitmap complement; it SHALL never exceed NUM_ENTRIES or underflow.
REQ-026 While flush is high, alloc_gnt SHALL be all zero; next state SHALL be all slots free, overriding same-cycle alloc and free.
REQ-027 Number of slots allocated per cycle SHALL NOT exceed ALLOC_PORTS nor current free slots.
REQ-028 Equivalent to old 12-entry lowest-index encoder when NUM_ENTRIES=12, ALLOC_PORTS=1, applied to the free vector.

Reset
REQ-029 On rst high at a rising edge, bitmap SHALL clear to all free, free_count SHALL be NUM_ENTRIES, empty=1, full=0.
REQ-030 rst SHALL take priority over flush, alloc and free; grants asserted in a reset cycle SHALL NOT take effect.
REQ-031 Outputs SHALL be defined from the first edge after rst; no X on alloc_gnt, alloc_idx or count.

Structure
REQ-032 Package alloc_pkg SHALL hold default NUM_ENTRIES, ALLOC_PORTS, FREE_PORTS constants and an idx_t typedef for the default width.
REQ-033 Sub-module prio_enc_n SHALL provide parametrised lowest-set-bit index plus found flag; slot_alloc SHALL chain ALLOC_PORTS instances, masking each granted bit before the next.
REQ-034 Bitmap and free_count SHALL be the only state; all grant logic combinational.

Verification
REQ-035 Reset then alloc_req=2'b11 -> alloc_gnt=2'b11, alloc_idx={1,0}; next cycle free_count=10.
REQ-036 Slots 0..10 busy, alloc_req=2'b11 -> port0 granted idx 11, port1 gnt=0; next cycle full=1, free_count=0.
REQ-037 Slot 3 busy, free_valid=2'b01 free_idx[0]=3 with alloc_req=2'b01 same cycle -> grant idx 0 (not 3); next cycle slot 3 free.
REQ-038 free_valid=2'b11 both free_idx=5 (slot 5 busy) -> free_count increments by exactly 1; free of free slot 7 -> no change.
REQ-039 8 slots busy, flush=1 with alloc_req=2'b11 -> alloc_gnt=0; next cycle free_count=12, empty=1.
REQ-040 rst asserted mid-traffic with alloc_req=2'b11 -> next cycle bitmap all free, free_count=12, no slot busy.

Source files
------------

// File: rtl/alloc_pkg.sv
// Shared constants for the slot allocator.
// Holds the default geometry (entries, alloc ports, free ports) and the
// slot-index type for that default geometry. Blocks with other geometries
// derive their own widths from their parameters.
package alloc_pkg;

  localparam int DEF_NUM_ENTRIES = 12;
  localparam int DEF_ALLOC_PORTS = 2;
  localparam int DEF_FREE_PORTS  = 2;
  localparam int DEF_IDX_W       = $clog2(DEF_NUM_ENTRIES);

  typedef logic [DEF_IDX_W-1:0] idx_t;

endpackage : alloc_pkg

// File: rtl/prio_enc_n.sv
// Lowest-set-bit priority encoder.
// Ports:
//   vec   - input vector to scan
//   found - high when any bit of vec is set
//   idx   - index of the lowest set bit, 0 when found is low
module prio_enc_n
  import alloc_pkg::*;
#(
  parameter int N     = DEF_NUM_ENTRIES,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the last hit written is the lowest set bit.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule : prio_enc_n

// File: rtl/slot_alloc.sv
// Multi-port slot allocator over a busy bitmap.
// Each cycle, requesting alloc ports receive the lowest free slots in port
// order; free ports return slots to the pool on the next edge.
//
// Request/grant semantics: alloc_req[p] is a request, alloc_gnt[p] is a
// combinational answer in the same cycle. A slot is consumed exactly when
// alloc_req[p] && alloc_gnt[p] at a rising edge (and neither rst nor flush
// is high). There is no back-pressure on the free side: a free request is
// always accepted, and ignored if it names an out-of-range or already-free
// slot.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   flush        - return every slot to free; blocks grants this cycle
//   alloc_req    - per-port allocation request
//   alloc_gnt    - per-port grant
//   alloc_idx    - granted slot per port, port p at [p*IDX_W +: IDX_W]; 0 if
//                  not granted
//   free_valid   - per-port free request
//   free_idx     - slot to free per port, port f at [f*IDX_W +: IDX_W]
//   free_count   - number of free slots (registered)
//   empty        - no slot in use
//   full         - no slot free
module slot_alloc
  import alloc_pkg::*;
#(
  parameter  int NUM_ENTRIES = DEF_NUM_ENTRIES,
  parameter  int ALLOC_PORTS = DEF_ALLOC_PORTS,
  parameter  int FREE_PORTS  = DEF_FREE_PORTS,
  localparam int IDX_W       = $clog2(NUM_ENTRIES),
  localparam int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [ALLOC_PORTS-1:0]       alloc_req,
  output logic [ALLOC_PORTS-1:0]       alloc_gnt,
  output logic [ALLOC_PORTS*IDX_W-1:0] alloc_idx,
  input  logic [FREE_PORTS-1:0]        free_valid,
  input  logic [FREE_PORTS*IDX_W-1:0]  free_idx,
  output logic [CNT_W-1:0]             free_count,
  output logic                         empty,
  output logic                         full
);

  logic [NUM_ENTRIES-1:0] busy_q;
  logic [NUM_ENTRIES-1:0] base_avail;
  logic [NUM_ENTRIES-1:0] set_mask;
  logic [NUM_ENTRIES-1:0] clr_mask;
  logic [NUM_ENTRIES-1:0] busy_d;
  logic [CNT_W-1:0]       cnt_d;

  // Slots freed this cycle are still busy in busy_q, so they are never
  // offered for allocation until the following cycle.
  assign base_avail = flush ? '0 : ~busy_q;

  // Grant chain: each stage takes the lowest available slot and removes it
  // from the vector seen by the next port. A non-requesting port passes the
  // vector through untouched.
  for (genvar p = 0; p < ALLOC_PORTS; p++) begin : g_port
    logic [NUM_ENTRIES-1:0] avail_in;
    logic [NUM_ENTRIES-1:0] avail_out;
    logic                   found;
    logic [IDX_W-1:0]       enc_idx;
    logic                   gnt;

    if (p == 0) begin : g_head
      assign avail_in = base_avail;
    end else begin : g_tail
      assign avail_in = g_port[p-1].avail_out;
    end

    prio_enc_n #(
      .N     (NUM_ENTRIES),
      .IDX_W (IDX_W)
    ) u_enc (
      .vec   (avail_in),
      .found (found),
      .idx   (enc_idx)
    );

    assign gnt       = alloc_req[p] & found;
    assign avail_out = gnt ? (avail_in & ~(NUM_ENTRIES'(1) << enc_idx)) : avail_in;

    assign alloc_gnt[p]                 = gnt;
    assign alloc_idx[p*IDX_W +: IDX_W]  = gnt ? enc_idx : '0;
  end

  // Everything removed along the chain is what gets allocated.
  assign set_mask = base_avail & ~g_port[ALLOC_PORTS-1].avail_out;

  // Duplicate frees collapse into one bit; out-of-range indices are dropped.
  always_comb begin
    clr_mask = '0;
    for (int f = 0; f < FREE_PORTS; f++) begin
      if (free_valid[f] && (int'(free_idx[f*IDX_W +: IDX_W]) < NUM_ENTRIES)) begin
        clr_mask[free_idx[f*IDX_W +: IDX_W]] = 1'b1;
      end
    end
  end

  // set_mask only touches free slots and clr_mask only matters on busy ones,
  // so the two never fight over a bit.
  always_comb begin
    busy_d = '0;
    if (!flush) begin
      busy_d = (busy_q & ~clr_mask) | set_mask;
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cnt_d = cnt_d + CNT_W'(!busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      free_count <= CNT_W'(NUM_ENTRIES);
    end else begin
      busy_q     <= busy_d;
      free_count <= cnt_d;
    end
  end

  // Decoded from the registered count, so they change on the same edge.
  assign empty = (free_count == CNT_W'(NUM_ENTRIES));
  assign full  = (free_count == '0);

endmodule : slot_alloc

// File: tb/tb_slot_alloc.sv
module tb_slot_alloc;
  import alloc_pkg::*;

  localparam int N  = 12;
  localparam int IW = 4;
  localparam int W  = 16;  // {gnt[2], idx[8], count[4], empty, full}

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] alloc_req;
  logic [1:0] alloc_gnt;
  logic [7:0] alloc_idx;
  logic [1:0] free_valid;
  logic [7:0] free_idx;
  logic [3:0] free_count;
  logic       empty;
  logic       full;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  logic [W-1:0] exp_q[$];

  // Model state: true means slot in use.
  bit mb[N];
  bit mb_next[N];

  slot_alloc dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_idx  (alloc_idx),
    .free_valid (free_valid),
    .free_idx   (free_idx),
    .free_count (free_count),
    .empty      (empty),
    .full       (full)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic r, input logic fl, input logic [1:0] req,
                     input logic [1:0] fv, input logic [3:0] f0, input logic [3:0] f1);
    @(posedge clk);
    #1;
    rst        = r;
    flush      = fl;
    alloc_req  = req;
    free_valid = fv;
    free_idx   = {f1, f0};
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'b00, 2'b00, 4'd0, 4'd0);
  endtask

  // ---------------- model + scoreboard ----------------
  // Allocation: walk ports in order, each requester takes the lowest slot
  // that is neither busy nor already handed out this cycle.
  always @(negedge clk) begin
    logic [1:0]   eg;
    logic [7:0]   ei;
    int           ecnt;
    bit           taken[N];
    logic [W-1:0] e;
    logic [W-1:0] g;
    int           fi;

    eg   = '0;
    ei   = '0;
    ecnt = 0;
    taken = mb;
    for (int p = 0; p < 2; p++) begin
      if (alloc_req[p] === 1'b1 && flush !== 1'b1) begin
        for (int s = 0; s < N; s++) begin
          if (!taken[s]) begin
            eg[p]          = 1'b1;
            ei[p*IW +: IW] = 4'(s);
            taken[s]       = 1'b1;
            break;
          end
        end
      end
    end
    for (int s = 0; s < N; s++) if (!mb[s]) ecnt++;
    e = {eg, ei, 4'(ecnt), ecnt == N, ecnt == 0};

    if (check_en) begin
      exp_q.push_back(e);
      e = exp_q.pop_front();
      g = {alloc_gnt, alloc_idx, free_count, empty, full};
      if (rst !== 1'b1) begin
        check("model_gnt", 32'(g[15:14]), 32'(e[15:14]));
        check("model_idx", 32'(g[13:6]), 32'(e[13:6]));
      end
      check("model_count", 32'(g[5:2]), 32'(e[5:2]));
      check("model_empty", 32'(g[1]), 32'(e[1]));
      check("model_full", 32'(g[0]), 32'(e[0]));
    end

    if (rst === 1'b1 || flush === 1'b1) begin
      for (int s = 0; s < N; s++) mb_next[s] = 1'b0;
    end else begin
      mb_next = taken;
      for (int f = 0; f < 2; f++) begin
        fi = int'(free_idx[f*IW +: IW]);
        if (free_valid[f] === 1'b1 && fi < N && mb[fi]) mb_next[fi] = 1'b0;
      end
    end
  end

  always @(posedge clk) mb <= mb_next;

  // ---------------- directed stimulus ----------------
  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    alloc_req  = '0;
    free_valid = '0;
    free_idx   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    check("rst_count", 32'(free_count), 32'd12);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);

    // Two grants from an empty pool.
    cyc(1'b0, 1'b0, 2'b11, 2'b00, 4'd0, 4'd0);
    check("first_gnt", 32'(alloc_gnt), 32'h3);
    check("first_idx", 32'(alloc_idx), 32'h10);
    idle();
    check("first_count", 32'(free_count), 32'd10);

    // Fill slots 2..10, then only slot 11 is left for two requesters.
    repeat (4) cyc(1'b0, 1'b0, 2'b11, 2'b00, 4'd0, 4'd0);
    cyc(1'b0, 1'b0, 2'b01, 2'b00, 4'd0, 4'd0);
    cyc(1'b0, 1'b0, 2'b11, 2'b00, 4'd0, 4'd0);
    check("last_gnt", 32'(alloc_gnt), 32'h1);
    check("last_idx", 32'(alloc_idx), 32'h0B);
    check("last_count", 32'(free_count), 32'd1);
    idle();
    check("full_flag", 32'(full), 32'd1);
    check("full_count", 32'(free_count), 32'd0);

    // Free everything except slot 3; slot 15 is out of range.
    cyc(1'b0, 1'b0, 2'b00, 2'b11, 4'd0, 4'd1);
    cyc(1'b0, 1'b0, 2'b00, 2'b11, 4'd2, 4'd4);
    cyc(1'b0, 1'b0, 2'b00, 2'b11, 4'd5, 4'd6);
    cyc(1'b0, 1'b0, 2'b00, 2'b11, 4'd7, 4'd8);
    cyc(1'b0, 1'b0, 2'b00, 2'b11, 4'd9, 4'd10);
    cyc(1'b0, 1'b0, 2'b00, 2'b11, 4'd11, 4'd15);

    // Free slot 3 while allocating: slot 3 must not be granted yet.
    cyc(1'b0, 1'b0, 2'b01, 2'b01, 4'd3, 4'd0);
    check("freeing_gnt", 32'(alloc_gnt), 32'h1);
    check("freeing_idx", 32'(alloc_idx), 32'h00);
    check("freeing_count", 32'(free_count), 32'd11);
    idle();
    check("freed_count", 32'(free_count), 32'd11);
    cyc(1'b0, 1'b0, 2'b11, 2'b00, 4'd0, 4'd0);
    check("refill_idx_a", 32'(alloc_idx), 32'h21);
    cyc(1'b0, 1'b0, 2'b11, 2'b00, 4'd0, 4'd0);
    check("refill_idx_b", 32'(alloc_idx), 32'h43);
    cyc(1'b0, 1'b0, 2'b01, 2'b00, 4'd0, 4'd0);
    check("refill_idx_c", 32'(alloc_idx), 32'h05);

    // Both ports free slot 5, then free an already-free slot 7.
    cyc(1'b0, 1'b0, 2'b00, 2'b11, 4'd5, 4'd5);
    check("dup_before", 32'(free_count), 32'd6);
    cyc(1'b0, 1'b0, 2'b00, 2'b01, 4'd7, 4'd0);
    check("dup_after", 32'(free_count), 32'd7);
    idle();
    check("free_of_free", 32'(free_count), 32'd7);

    // Eight busy, then flush with requests pending.
    cyc(1'b0, 1'b0, 2'b11, 2'b00, 4'd0, 4'd0);
    check("pre_flush_idx", 32'(alloc_idx), 32'h65);
    cyc(1'b0, 1'b0, 2'b01, 2'b00, 4'd0, 4'd0);
    cyc(1'b0, 1'b1, 2'b11, 2'b00, 4'd0, 4'd0);
    check("flush_gnt", 32'(alloc_gnt), 32'h0);
    check("flush_before", 32'(free_count), 32'd4);
    idle();
    check("flush_count", 32'(free_count), 32'd12);
    check("flush_empty", 32'(empty), 32'd1);

    // Reset in the middle of traffic.
    cyc(1'b0, 1'b0, 2'b11, 2'b00, 4'd0, 4'd0);
    cyc(1'b0, 1'b0, 2'b11, 2'b00, 4'd0, 4'd0);
    cyc(1'b1, 1'b0, 2'b11, 2'b00, 4'd0, 4'd0);
    check("midrst_before", 32'(free_count), 32'd8);
    idle();
    check("midrst_count", 32'(free_count), 32'd12);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_full", 32'(full), 32'd0);

    // Mixed traffic, checked by the model every cycle.
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom_range(0, 63) == 0),
          1'($urandom_range(0, 31) == 0),
          2'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)),
          4'($urandom_range(0, 13)),
          4'($urandom_range(0, 15)));
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_slot_alloc
